pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// PLL phase-adjust controller.
// Sequences the PLL reset, waits for lock, then serves phase-adjust requests by
// driving PHASESEL/PHASEDIR, issuing a train of PHASESTEP pulses and a final
// PHASELOADREG pulse, and waiting for the PLL to relock. Every output is a
// flop, so no input reaches an output combinationally.
module pll_phase_ctrl #(
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned STEP_CYCLES  = 4
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       lock,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_sel,
  input  logic       req_dir,
  input  logic [3:0] req_steps,
  output logic       pll_rst,
  output logic       phasesel1,
  output logic       phasesel0,
  output logic       phasedir,
  output logic       phasestep,
  output logic       phaseloadreg,
  output logic       locked,
  output logic       done,
  output logic       err
);

  // Phase counter covers both the PLL reset hold and the step/setup/load widths.
  localparam int unsigned CntMax = (RST_CYCLES > STEP_CYCLES) ? RST_CYCLES : STEP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned ToW    = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StPrst,
    StWlock,
    StIdle,
    StSetup,
    StStepHi,
    StStepLo,
    StLoad,
    StRelock
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [ToW-1:0]  to_q, to_d;
  logic [1:0]      sync_q;
  logic            lock_s;

  logic [1:0]      sel_q, sel_d;
  logic            dir_q, dir_d;
  logic [3:0]      steps_q, steps_d;

  logic            err_set;
  logic            done_set;

  logic            pll_rst_q;
  logic            phasestep_q;
  logic            phaseloadreg_q;
  logic            req_ready_q;
  logic            locked_q;
  logic            done_q;
  logic            err_q;

  logic            rst_last;
  logic            step_last;
  logic            to_last;

  assign lock_s    = sync_q[1];
  assign rst_last  = (cnt_q == CntW'(RST_CYCLES - 1));
  assign step_last = (cnt_q == CntW'(STEP_CYCLES - 1));
  assign to_last   = (to_q == ToW'(LOCK_TIMEOUT - 1));

  // Two-flop synchroniser for the asynchronous PLL lock indication.
  always_ff @(posedge clki) begin
    if (rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], lock};
    end
  end

  // Next-state logic, request latching and error/done event detection.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    dir_d    = dir_q;
    steps_d  = steps_q;
    err_set  = 1'b0;
    done_set = 1'b0;

    unique case (state_q)
      StPrst: begin
        if (rst_last) begin
          state_d = StWlock;
        end
      end

      StWlock: begin
        if (lock_s) begin
          state_d = StIdle;
        end else if (to_last) begin
          state_d = StPrst;
          err_set = 1'b1;
        end
      end

      StIdle: begin
        // A handshake already seen by the requester wins over a same-cycle lock
        // loss; RELOCK will then catch the missing lock via its timeout.
        if (req_valid) begin
          sel_d   = req_sel;
          dir_d   = req_dir;
          steps_d = req_steps;
          state_d = StSetup;
        end else if (!lock_s) begin
          state_d = StPrst;
          err_set = 1'b1;
        end
      end

      StSetup: begin
        if (step_last) begin
          state_d = (steps_q == 4'd0) ? StLoad : StStepHi;
        end
      end

      StStepHi: begin
        if (step_last) begin
          state_d = StStepLo;
        end
      end

      StStepLo: begin
        if (step_last) begin
          steps_d = steps_q - 4'd1;
          state_d = (steps_q == 4'd1) ? StLoad : StStepHi;
        end
      end

      StLoad: begin
        if (step_last) begin
          state_d = StRelock;
        end
      end

      StRelock: begin
        if (lock_s) begin
          state_d  = StIdle;
          done_set = 1'b1;
        end else if (to_last) begin
          state_d = StPrst;
          err_set = 1'b1;
        end
      end

      default: begin
        state_d = StPrst;
      end
    endcase
  end

  // Both counters restart on every state entry and saturate instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    to_d  = to_q;
    if (state_d != state_q) begin
      cnt_d = '0;
      to_d  = '0;
    end else begin
      if (cnt_q != {CntW{1'b1}}) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (to_q != ToW'(LOCK_TIMEOUT)) begin
        to_d = to_q + 1'b1;
      end
    end
  end

  // State, counters, latched request and registered outputs.
  always_ff @(posedge clki) begin
    if (rst) begin
      state_q        <= StPrst;
      cnt_q          <= '0;
      to_q           <= '0;
      sel_q          <= 2'b00;
      dir_q          <= 1'b0;
      steps_q        <= 4'd0;
      pll_rst_q      <= 1'b1;
      phasestep_q    <= 1'b0;
      phaseloadreg_q <= 1'b0;
      req_ready_q    <= 1'b0;
      locked_q       <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      sel_q          <= sel_d;
      dir_q          <= dir_d;
      steps_q        <= steps_d;
      // Outputs decode the next state so they line up with state_q.
      pll_rst_q      <= (state_d == StPrst);
      phasestep_q    <= (state_d == StStepHi);
      phaseloadreg_q <= (state_d == StLoad);
      req_ready_q    <= (state_d == StIdle);
      locked_q       <= (state_d == StIdle);
      done_q         <= done_set;
      err_q          <= err_q | err_set;
    end
  end

  assign pll_rst      = pll_rst_q;
  assign phasesel1    = sel_q[1];
  assign phasesel0    = sel_q[0];
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = phaseloadreg_q;
  assign req_ready    = req_ready_q;
  assign locked       = locked_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with default parameters.
module tb_pll_phase_ctrl;

  logic       clki = 1'b0;
  logic       rst;
  logic       lock;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_sel;
  logic       req_dir;
  logic [3:0] req_steps;
  logic       pll_rst;
  logic       phasesel1;
  logic       phasesel0;
  logic       phasedir;
  logic       phasestep;
  logic       phaseloadreg;
  logic       locked;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  pll_phase_ctrl dut (
    .clki         (clki),
    .rst          (rst),
    .lock         (lock),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_sel      (req_sel),
    .req_dir      (req_dir),
    .req_steps    (req_steps),
    .pll_rst      (pll_rst),
    .phasesel1    (phasesel1),
    .phasesel0    (phasesel0),
    .phasedir     (phasedir),
    .phasestep    (phasestep),
    .phaseloadreg (phaseloadreg),
    .locked       (locked),
    .done         (done),
    .err          (err)
  );

  always #5 clki = ~clki;

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clki);
    #1;
  endtask

  function automatic logic [9:0] outs();
    return {pll_rst, phasesel1, phasesel0, phasedir, phasestep, phaseloadreg,
            req_ready, locked, done, err};
  endfunction

  task automatic test_reset();
    rst = 1'b1; lock = 1'b0; req_valid = 1'b0;
    req_sel = 2'd0; req_dir = 1'b0; req_steps = 4'd0;
    repeat (5) tick();
    checks++;
    if (outs() !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", outs(), 10'b10_0000_0000);
    end
  endtask

  task automatic test_power_up();
    int fall = 0;
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (fall == 0 && pll_rst === 1'b0) fall = i;
    end
    checks++;
    if (fall != 16) begin
      errors++;
      $display("FAIL powerup_pll_rst_len: got %0d expected %0d", fall, 16);
    end
    checks++;
    if (outs() !== 10'b0) begin
      errors++;
      $display("FAIL powerup_wlock_outs: got %b expected %b", outs(), 10'b0);
    end
    lock = 1'b1;
    tick();
    tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL powerup_locked_early: got %b expected %b", locked, 1'b0);
    end
    tick();
    checks++;
    if ({locked, req_ready, err} !== 3'b110) begin
      errors++;
      $display("FAIL powerup_locked: got %b expected %b", {locked, req_ready, err}, 3'b110);
    end
  endtask

  // Present a request and wait for the accepting edge; returns at k=0 of the
  // transaction with req_valid still high.
  task automatic issue(input logic [1:0] sel, input logic dir, input logic [3:0] steps,
                       input string name);
    logic rdy;
    logic accepted = 1'b0;
    req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      rdy = req_ready;
      tick();
      if (rdy === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    checks++;
    if (accepted !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: got %b expected %b", name, accepted, 1'b1);
    end
  endtask

  // Cycle-by-cycle expected waveform: SETUP(4), N x (HI 4, LO 4), LOAD 4, RELOCK 1.
  task automatic check_txn(input logic [1:0] sel, input logic dir, input logic [3:0] steps,
                           input string name);
    int n = int'(steps);
    int l0 = 4 + 8 * n;
    int pulses = 0;
    logic prev = 1'b0;
    logic [6:0] obs;
    logic [6:0] expv;
    for (int k = 0; k <= l0 + 5; k++) begin
      if (k > 0) tick();
      expv = {(k >= 4 && k < l0 && ((k - 4) % 8) < 4),
              (k >= l0 && k < l0 + 4),
              (k == l0 + 5),
              (k == l0 + 5),
              sel, dir};
      obs = {phasestep, phaseloadreg, done, req_ready, phasesel1, phasesel0, phasedir};
      checks++;
      if (obs !== expv) begin
        errors++;
        $display("FAIL %s_k%0d: got %b expected %b", name, k, obs, expv);
      end
      if (phasestep === 1'b1 && prev === 1'b0) pulses++;
      prev = phasestep;
    end
    checks++;
    if (pulses != n) begin
      errors++;
      $display("FAIL %s_pulses: got %0d expected %0d", name, pulses, n);
    end
    checks++;
    if ({locked, err} !== 2'b10) begin
      errors++;
      $display("FAIL %s_end: got %b expected %b", name, {locked, err}, 2'b10);
    end
  endtask

  task automatic test_phase_step();
    issue(2'd2, 1'b1, 4'd3, "step3");
    req_valid = 1'b0;
    check_txn(2'd2, 1'b1, 4'd3, "step3");
  endtask

  task automatic test_zero_steps();
    issue(2'd1, 1'b0, 4'd0, "step0");
    req_valid = 1'b0;
    check_txn(2'd1, 1'b0, 4'd0, "step0");
  endtask

  // Second request is held during the first and must not disturb it.
  task automatic test_back_to_back();
    issue(2'd3, 1'b0, 4'd1, "b2b_a");
    req_sel = 2'd0; req_dir = 1'b1; req_steps = 4'd2;
    check_txn(2'd3, 1'b0, 4'd1, "b2b_a");
    issue(2'd0, 1'b1, 4'd2, "b2b_b");
    req_valid = 1'b0;
    check_txn(2'd0, 1'b1, 4'd2, "b2b_b");
  endtask

  task automatic test_rst_mid_step();
    int fall = 0;
    int bad = 0;
    issue(2'd1, 1'b1, 4'd5, "mid");
    req_valid = 1'b0;
    for (int k = 1; k <= 13; k++) tick();
    checks++;
    if (phasestep !== 1'b1) begin
      errors++;
      $display("FAIL mid_second_hi: got %b expected %b", phasestep, 1'b1);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (outs() !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL mid_abort: got %b expected %b", outs(), 10'b10_0000_0000);
    end
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if ((phasestep | phaseloadreg | done) !== 1'b0) bad++;
      if (fall == 0 && pll_rst === 1'b0) fall = i;
      if (locked === 1'b1) break;
    end
    checks++;
    if (fall != 16) begin
      errors++;
      $display("FAIL mid_prst_len: got %0d expected %0d", fall, 16);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_stray_pulses: got %0d expected %0d", bad, 0);
    end
    checks++;
    if ({locked, err} !== 2'b10) begin
      errors++;
      $display("FAIL mid_relock: got %b expected %b", {locked, err}, 2'b10);
    end
  endtask

  task automatic test_lock_loss();
    int rdy_hi = 0;
    int waited = 0;
    lock = 1'b0;
    tick();
    tick();
    checks++;
    if ({err, locked, pll_rst} !== 3'b010) begin
      errors++;
      $display("FAIL loss_early: got %b expected %b", {err, locked, pll_rst}, 3'b010);
    end
    tick();
    checks++;
    if ({err, locked, pll_rst, req_ready} !== 4'b1010) begin
      errors++;
      $display("FAIL loss_prst: got %b expected %b", {err, locked, pll_rst, req_ready}, 4'b1010);
    end
    for (int i = 0; i < 30; i++) begin
      tick();
      if (req_ready !== 1'b0) rdy_hi++;
    end
    checks++;
    if (rdy_hi != 0) begin
      errors++;
      $display("FAIL loss_ready_low: got %0d expected %0d", rdy_hi, 0);
    end
    lock = 1'b1;
    while (locked !== 1'b1 && waited < 100) begin
      tick();
      waited++;
    end
    checks++;
    if ({locked, err} !== 2'b11) begin
      errors++;
      $display("FAIL loss_relock: got %b expected %b", {locked, err}, 2'b11);
    end
  endtask

  task automatic test_lock_timeout();
    int fall = 0;
    int low = 1;
    int hi = 1;
    int waited = 0;
    logic last_err = 1'bx;
    rst = 1'b1; lock = 1'b0;
    repeat (3) tick();
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL to_err_cleared: got %b expected %b", err, 1'b0);
    end
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pll_rst === 1'b0) begin
        fall = i;
        break;
      end
    end
    checks++;
    if (fall != 16) begin
      errors++;
      $display("FAIL to_prst_len: got %0d expected %0d", fall, 16);
    end
    last_err = err;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (pll_rst === 1'b1) break;
      low++;
      last_err = err;
    end
    checks++;
    if (low != 4096) begin
      errors++;
      $display("FAIL to_wlock_len: got %0d expected %0d", low, 4096);
    end
    checks++;
    if ({last_err, err} !== 2'b01) begin
      errors++;
      $display("FAIL to_err_set: got %b expected %b", {last_err, err}, 2'b01);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (pll_rst !== 1'b1) break;
      hi++;
    end
    checks++;
    if (hi != 16) begin
      errors++;
      $display("FAIL to_retry_prst_len: got %0d expected %0d", hi, 16);
    end
    lock = 1'b1;
    while (locked !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    checks++;
    if ({locked, err} !== 2'b11) begin
      errors++;
      $display("FAIL to_relock: got %b expected %b", {locked, err}, 2'b11);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_phase_step();
    test_zero_steps();
    test_back_to_back();
    test_rst_mid_step();
    test_lock_loss();
    test_lock_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
